// File: rtl/bus_master_engine_pkg.sv
// Shared definitions for the bus master engine: default widths,
// command direction constants and the engine state encoding.
package bus_master_engine_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 4;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_RTAIL = 3'd3,
    ST_DONE  = 3'd4
  } bus_state_t;

endpackage

// File: rtl/bus_master_engine.sv
// Bus master engine: accepts single/burst read or write commands from a
// local client, requests the shared bus, issues one beat per granted
// cycle and returns read data one cycle after each read address.
module bus_master_engine
  import bus_master_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wd_data,
  output logic              wd_pop,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              done,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din
);

  localparam logic [LEN_W-1:0] BEAT_ONE = LEN_W'(1);

  bus_state_t        state;
  logic [LEN_W-1:0]  beat;
  logic              rd_pend;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;

  logic              xfer_beat;
  logic              last_beat;

  // A beat only completes in a granted XFER cycle.
  assign xfer_beat = (state == ST_XFER) && m_grant;
  assign last_beat = (beat == len_q);

  // Control FSM: state, beat counter and the pending-read-data flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      beat    <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= xfer_beat && (wr_q == CMD_RD);
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            beat  <= '0;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_grant) begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!m_grant) begin
            // Grant lost: re-request and resume at the same beat.
            state <= ST_REQ;
          end else if (last_beat) begin
            state <= (wr_q == CMD_WR) ? ST_DONE : ST_RTAIL;
          end else begin
            beat <= beat + BEAT_ONE;
          end
        end
        ST_RTAIL: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Command fields are held for the whole transaction once accepted.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cmd_valid) begin
      wr_q   <= cmd_wr;
      addr_q <= cmd_addr;
      len_q  <= cmd_len;
    end
  end

  // Output decode; everything is forced to 0 while reset is asserted and
  // bus data/address stay 0 outside granted beats so the bus can be OR-muxed.
  always_comb begin
    cmd_ready = 1'b0;
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    m_dout    = '0;
    wd_pop    = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    done      = 1'b0;
    if (reset_n) begin
      cmd_ready = (state == ST_IDLE);
      m_req     = (state == ST_REQ) || (state == ST_XFER);
      done      = (state == ST_DONE);
      if (xfer_beat) begin
        // Address wraps naturally at 2^ADDR_W.
        m_addr = addr_q + ADDR_W'(beat);
        if (wr_q == CMD_WR) begin
          m_wr   = 1'b1;
          m_dout = wd_data;
          wd_pop = 1'b1;
        end
      end
      // Read data arrives on m_din the cycle after its address.
      if (rd_pend) begin
        rsp_valid = 1'b1;
        rsp_rdata = m_din;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_engine.sv
// Self-checking bench for bus_master_engine with a RAM slave on the bus
// and a transaction-level model of expected beats, responses and dones.
module tb_bus_master_engine;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wd_data;
  logic        wd_pop;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        done;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic        m_grant;
  logic [31:0] m_din;

  logic        pre_we;
  logic [15:0] pre_a;
  logic [31:0] pre_d;
  logic [31:0] ram [0:65535];
  logic [31:0] mdl [0:65535];

  beat_t       exp_wr[$];
  beat_t       exp_rd[$];
  logic [31:0] wdq[$];
  logic [31:0] wsrc[$];
  logic [31:0] rsp_log[$];
  logic [15:0] rd_addr_log[$];
  int          done_log[$];

  int          checks;
  int          errs;
  int          cyc;
  int          exp_done;
  int          done_count;
  int          pop_count;
  int          first_rsp;
  int          wr_nogrant;
  logic        req_at_rsp;
  logic        pop_flag;
  logic [15:0] prev_addr;
  logic [15:0] last_wa;
  logic [31:0] last_wd;

  bus_master_engine #(.ADDR_W(16), .DATA_W(32), .LEN_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wd_data(wd_data),
    .wd_pop(wd_pop), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .done(done),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: write on granted write beats, registered read data.
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (m_req && m_grant && m_wr) ram[m_addr] <= m_dout;
    m_din <= ram[m_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    beat_t b;
    forever begin
      @(negedge clk);
      if (!(m_req && m_grant)) check("bus_quiet", 64'({m_wr, m_addr, m_dout}), 64'd0);
      check("pop_is_wr", 64'(wd_pop), 64'(m_wr));
      pop_flag = wd_pop;
      if (m_wr && !m_grant) wr_nogrant++;
      if (m_wr) begin
        pop_count++;
        last_wa = m_addr;
        last_wd = m_dout;
        check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          b = exp_wr.pop_front();
          check("wr_addr", 64'(m_addr), 64'(b.a));
          check("wr_data", 64'(m_dout), 64'(b.d));
        end
      end
      if (rsp_valid) begin
        rsp_log.push_back(rsp_rdata);
        rd_addr_log.push_back(prev_addr);
        req_at_rsp = m_req;
        if (first_rsp < 0) first_rsp = cyc;
        check("rsp_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) begin
          b = exp_rd.pop_front();
          check("rd_addr", 64'(prev_addr), 64'(b.a));
          check("rd_data", 64'(rsp_rdata), 64'(b.d));
        end
      end
      if (done) begin
        done_count++;
        done_log.push_back(cyc);
        check("done_expected", 64'(exp_done > 0), 64'd1);
        if (exp_done > 0) exp_done--;
      end
      prev_addr = m_addr;
    end
  endtask

  task automatic wd_driver();
    forever begin
      @(posedge clk);
      #1;
      if (pop_flag && wdq.size() > 0) wdq.delete(0);
      wd_data = (wdq.size() > 0) ? wdq[0] : 32'd0;
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    mdl[a] = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [3:0] len,
                       input bit hold, output int acc);
    bit ok;
    logic [15:0] ai;
    ok = 1'b0;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      ai = a + 16'(i);
      if (wr) begin
        exp_wr.push_back({ai, wsrc[i]});
        wdq.push_back(wsrc[i]);
        mdl[ai] = wsrc[i];
      end else begin
        exp_rd.push_back({ai, mdl[ai]});
      end
    end
    wd_data = (wdq.size() > 0) ? wdq[0] : 32'd0;
    exp_done++;
    acc = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (cmd_ready) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    check("accept_wait", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (done_count >= n) ok = 1'b1;
    end
    check("done_wait", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int acc2;
    int pops0;
    int dones0;
    bit ok;
    logic [15:0] touched[$];

    checks = 0; errs = 0; cyc = 0; exp_done = 0; done_count = 0; pop_count = 0;
    first_rsp = -1; wr_nogrant = 0; req_at_rsp = 1'b0; pop_flag = 1'b0;
    prev_addr = '0; last_wa = '0; last_wd = '0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_data = '0; m_grant = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;

    fork
      monitor();
      wd_driver();
    join_none

    // Preload slave and model while reset is held.
    for (int i = 0; i < 4; i++) poke(16'h0020 + 16'(i), 32'(i + 1));
    poke(16'hFFFF, 32'hAAAA_0001);
    poke(16'h0000, 32'hAAAA_0002);
    for (int i = 0; i < 8; i++) poke(16'h0040 + 16'(i), 32'd0);

    @(negedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rel_m_req", 64'(m_req), 64'd0);
    check("rel_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;

    // Single write, immediate grant.
    pops0 = pop_count;
    wsrc = '{32'hDEAD_BEEF};
    issue(1'b1, 16'h0010, 4'd0, 1'b0, acc);
    wait_done(1);
    check("w1_done_latency", 64'(done_log[0] - acc), 64'd3);
    check("w1_pops", 64'(pop_count - pops0), 64'd1);
    check("w1_addr", 64'(last_wa), 64'h0010);
    check("w1_data", 64'(last_wd), 64'hDEAD_BEEF);
    check("w1_ram", 64'(ram[16'h0010]), 64'hDEAD_BEEF);

    // 4-beat read from preloaded RAM.
    rsp_log.delete();
    first_rsp = -1;
    issue(1'b0, 16'h0020, 4'd3, 1'b0, acc);
    wait_done(2);
    check("r4_count", 64'(rsp_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++)
      check("r4_data", 64'(rsp_log[i]), 64'(i + 1));
    check("r4_rsp_latency", 64'(first_rsp - acc), 64'd3);
    check("r4_done_latency", 64'(done_log[1] - acc), 64'd7);
    check("r4_req_low_tail", 64'(req_at_rsp), 64'd0);

    // 4-beat write with grant withdrawn for 2 cycles after beat 1.
    pops0 = pop_count;
    wsrc = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    issue(1'b1, 16'h0030, 4'd3, 1'b0, acc);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (m_wr && m_addr == 16'h0031) ok = 1'b1;
    end
    check("w4_beat1_wait", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    m_grant = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m_grant = 1'b1;
    wait_done(3);
    check("w4_pops", 64'(pop_count - pops0), 64'd4);
    check("w4_wr_nogrant", 64'(wr_nogrant), 64'd0);
    for (int i = 0; i < 4; i++)
      check("w4_ram", 64'(ram[16'h0030 + 16'(i)]), 64'(32'hC0DE_0000 + 32'(i)));

    // Address wrap on a 2-beat read.
    rsp_log.delete();
    rd_addr_log.delete();
    issue(1'b0, 16'hFFFF, 4'd1, 1'b0, acc);
    wait_done(4);
    check("wrap_count", 64'(rd_addr_log.size()), 64'd2);
    if (rd_addr_log.size() == 2) begin
      check("wrap_addr0", 64'(rd_addr_log[0]), 64'hFFFF);
      check("wrap_addr1", 64'(rd_addr_log[1]), 64'h0000);
      check("wrap_data0", 64'(rsp_log[0]), 64'hAAAA_0001);
      check("wrap_data1", 64'(rsp_log[1]), 64'hAAAA_0002);
    end

    // Reset during beat 2 of an 8-beat write.
    pops0  = pop_count;
    dones0 = done_count;
    wsrc.delete();
    for (int i = 0; i < 8; i++) wsrc.push_back(32'h0000_0100 + 32'(i));
    issue(1'b1, 16'h0040, 4'd7, 1'b0, acc);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (m_wr && m_addr == 16'h0041) ok = 1'b1;
    end
    check("rst_beat1_wait", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_m_wr", 64'(m_wr), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check("rst_next_m_req", 64'(m_req), 64'd0);
    // The abandoned burst leaves beats 2..7 unwritten.
    exp_wr.delete();
    wdq.delete();
    exp_done = 0;
    for (int i = 2; i < 8; i++) mdl[16'h0040 + 16'(i)] = 32'd0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wd_data = 32'd0;
    @(negedge clk);
    #1;
    check("rst_rel_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rel_m_req", 64'(m_req), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_count - dones0), 64'd0);
    check("rst_pops", 64'(pop_count - pops0), 64'd2);
    check("rst_ram0", 64'(ram[16'h0040]), 64'h0100);
    check("rst_ram1", 64'(ram[16'h0041]), 64'h0101);
    for (int i = 2; i < 8; i++)
      check("rst_ram_untouched", 64'(ram[16'h0040 + 16'(i)]), 64'd0);

    // Back-to-back write then read of the same address, cmd_valid held.
    rsp_log.delete();
    dones0 = done_count;
    wsrc = '{32'h5A5A_1234};
    issue(1'b1, 16'h0050, 4'd0, 1'b1, acc);
    issue(1'b0, 16'h0050, 4'd0, 1'b0, acc2);
    wait_done(dones0 + 2);
    check("b2b_gap", 64'(acc2 - done_log[dones0]), 64'd1);
    check("b2b_rsp_count", 64'(rsp_log.size()), 64'd1);
    if (rsp_log.size() == 1) check("b2b_rdata", 64'(rsp_log[0]), 64'h5A5A_1234);

    // Every word the model knows about must match the slave RAM.
    touched = '{16'h0010, 16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0030, 16'h0031,
                16'h0032, 16'h0033, 16'h0040, 16'h0041, 16'h0047, 16'h0050, 16'hFFFF, 16'h0000};
    foreach (touched[i]) check("ram_vs_model", 64'(ram[touched[i]]), 64'(mdl[touched[i]]));
    check("left_exp_wr", 64'(exp_wr.size()), 64'd0);
    check("left_exp_rd", 64'(exp_rd.size()), 64'd0);
    check("left_exp_done", 64'(exp_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
